// File: rtl/biquad_coeff_sequencer.sv
// Wishbone master that copies the shadow coefficient buffer into the biquad chain, then pulses notch_update.
// Optional read-back verification of every written word: define BQ_SEQ_READBACK_VERIFY_EN.
module biquad_coeff_sequencer #(
    parameter int NENTRY  = 64,
    parameter int TIMEOUT = 255,
    parameter int MAXRTY  = 3
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        cfg_we_i,
    input  logic [5:0]  cfg_idx_i,
    input  logic [31:0] cfg_dat_i,
    input  logic        commit_i,
    input  logic [6:0]  len_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [7:0]  err_cnt_o,
    output logic        notch_update_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [7:0]  m_adr_o,
    output logic [31:0] m_dat_o,
    output logic [3:0]  m_sel_o,
    input  logic        m_ack_i,
    input  logic        m_err_i,
    input  logic        m_rty_i,
    input  logic [31:0] m_dat_i
);

    typedef enum logic [3:0] {
        S_IDLE, S_RD, S_WR, S_RTYW, S_NEXT, S_RB, S_CMP, S_UPD, S_DONE
    } state_t;

    localparam logic [6:0] LEN_MAX  = 7'(NENTRY);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] RTY_MAX  = 8'(MAXRTY);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_shadow [NENTRY];
    logic [31:0] r_word;
    logic [5:0]  r_idx;
    logic [6:0]  r_len;
    logic [7:0]  r_tmo;
    logic [7:0]  r_rty;
    logic        r_err;
    logic [7:0]  r_err_cnt;
    logic        w_tmo;
    logic        w_any_term;
    logic        w_rty_spent;
    logic        w_last;
    logic        w_fail;
    logic        w_bus;

    assign w_tmo       = (r_tmo == TMO_LAST);
    assign w_any_term  = m_err_i | m_rty_i | m_ack_i;
    assign w_rty_spent = (r_rty == RTY_MAX);
    assign w_last      = (({1'b0, r_idx} + 7'd1) == r_len);

    // Shadow buffer: no reset, one-cycle read issued in RD; host writes only land while idle.
    always_ff @(posedge wb_clk_i) begin
        if (cfg_we_i && r_state == S_IDLE) begin
            r_shadow[cfg_idx_i] <= cfg_dat_i;
        end
        if (r_state == S_RD) begin
            r_word <= r_shadow[r_idx];
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (commit_i) w_next = S_RD;
            S_RD:   w_next = (r_len == '0) ? S_UPD : S_WR;
            S_WR: begin
                if (m_err_i) begin
                    w_next = S_NEXT;
                end else if (m_rty_i) begin
                    w_next = w_rty_spent ? S_NEXT : S_RTYW;
                end else if (m_ack_i) begin
`ifdef BQ_SEQ_READBACK_VERIFY_EN
                    w_next = S_RB;
`else
                    w_next = S_NEXT;
`endif
                end else if (w_tmo) begin
                    w_next = S_NEXT;
                end
            end
            S_RTYW: w_next = S_WR;
            S_NEXT: w_next = w_last ? S_UPD : S_RD;
`ifdef BQ_SEQ_READBACK_VERIFY_EN
            S_RB: begin
                if (m_ack_i && !m_err_i && !m_rty_i) begin
                    w_next = S_CMP;
                end else if (w_any_term || w_tmo) begin
                    w_next = S_NEXT;
                end
            end
            S_CMP:  w_next = S_NEXT;
`endif
            S_UPD:  w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_bus          = (r_state == S_WR) || (r_state == S_RB);
        busy_o         = (r_state != S_IDLE);
        done_o         = (r_state == S_DONE);
        notch_update_o = (r_state == S_UPD);
        m_cyc_o        = w_bus;
        m_stb_o        = w_bus;
        m_we_o         = (r_state == S_WR);
        m_adr_o        = w_bus ? {r_idx, 2'b00} : 8'h00;
        m_dat_o        = (r_state == S_WR) ? r_word : 32'h0;
    end

`ifdef BQ_SEQ_READBACK_VERIFY_EN
    logic [31:0] r_rb_dat;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_rb_dat <= '0;
        end else if (r_state == S_RB && m_ack_i) begin
            r_rb_dat <= m_dat_i;
        end
    end
`else
    logic w_unused_rdata;
    assign w_unused_rdata = ^m_dat_i;
`endif

    // A read-back that ends in rty is treated as a failed read rather than retried.
    always_comb begin
        w_fail = 1'b0;
        case (r_state)
            S_WR:  w_fail = m_err_i | (m_rty_i & w_rty_spent) | (w_tmo & ~w_any_term);
`ifdef BQ_SEQ_READBACK_VERIFY_EN
            S_RB:  w_fail = m_err_i | m_rty_i | (w_tmo & ~w_any_term);
            S_CMP: w_fail = (r_rb_dat != r_word);
`endif
            default: w_fail = 1'b0;
        endcase
    end

    // The timeout counter restarts on every state change, so each issue and retry gets a full window.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_idx     <= '0;
            r_len     <= '0;
            r_tmo     <= '0;
            r_rty     <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_tmo <= (w_next == r_state) ? r_tmo + 8'd1 : 8'd0;
            if (r_state == S_IDLE && commit_i) begin
                r_idx     <= '0;
                r_len     <= (len_i > LEN_MAX) ? LEN_MAX : len_i;
                r_err     <= 1'b0;
                r_err_cnt <= '0;
            end
            if (r_state == S_RD) begin
                r_rty <= '0;
            end else if (r_state == S_WR && m_rty_i && !m_err_i) begin
                r_rty <= r_rty + 8'd1;
            end
            if (r_state == S_NEXT && !w_last) begin
                r_idx <= r_idx + 6'd1;
            end
            if (w_fail) begin
                r_err <= 1'b1;
                if (r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end
        end
    end

    assign err_o     = r_err;
    assign err_cnt_o = r_err_cnt;
    assign m_sel_o   = 4'hF;

endmodule

// File: tb/tb_biquad_coeff_sequencer.sv
// Scoreboard bench for biquad_coeff_sequencer: a reference model queues the expected bus transfers,
// a monitor pops and compares them, and a randomized Wishbone slave injects latency, rty, err and stalls.
module tb_biquad_coeff_sequencer;

    localparam int TIMEOUT = 255;
    localparam int MAXRTY  = 3;

    typedef struct {
        bit          we;
        logic [7:0]  adr;
        logic [31:0] dat;
    } xfer_t;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni;
    logic        cfg_we_i, commit_i;
    logic [5:0]  cfg_idx_i;
    logic [31:0] cfg_dat_i;
    logic [6:0]  len_i;
    logic        busy_o, done_o, err_o, notch_update_o;
    logic [7:0]  err_cnt_o;
    logic        m_cyc_o, m_stb_o, m_we_o;
    logic [7:0]  m_adr_o;
    logic [31:0] m_dat_o;
    logic [3:0]  m_sel_o;
    logic        m_ack_i, m_err_i, m_rty_i;
    logic [31:0] m_dat_i;

    biquad_coeff_sequencer dut (
        .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
        .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_dat_i(cfg_dat_i),
        .commit_i(commit_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_cnt_o(err_cnt_o),
        .notch_update_o(notch_update_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_adr_o(m_adr_o),
        .m_dat_o(m_dat_o), .m_sel_o(m_sel_o),
        .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_rty_i(m_rty_i), .m_dat_i(m_dat_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cnt = 0;
    logic [31:0] shadow_m [64];
    xfer_t       exp_q [$];
    int          exp_errs, exp_xfers;
    bit          exp_stall;
    int          err_idx = -1, stall_idx = -1, rty_idx = -1, rty_n = 0, bad_rd_idx = -1, max_lat = 0;
    int          rty_done = 0;
    int          notch_n, done_n, n_issue, stall_cyc, busy_rise, notch_at, done_at, commit_cnt;

    always @(posedge wb_clk_i) cnt <= cnt + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: list of bus transfers and the error count each committed sequence should produce.
    task automatic buildExpected(input int len_req);
        int    n;
        int    k;
        bit    ok;
        xfer_t x;
        n = (len_req > 64) ? 64 : len_req;
        exp_errs = 0; exp_xfers = 0; exp_stall = 0;
        for (int i = 0; i < n; i++) begin
            ok = 1;
            x.we = 1; x.adr = 8'(i * 4); x.dat = shadow_m[i];
            if (i == err_idx) begin
                k = 1; ok = 0;
            end else if (i == stall_idx) begin
                k = 1; ok = 0; exp_stall = 1;
            end else if (i == rty_idx) begin
                k = (rty_n > MAXRTY) ? MAXRTY + 1 : rty_n + 1;
                ok = (rty_n <= MAXRTY);
            end else begin
                k = 1;
            end
            for (int j = 0; j < k; j++) begin
                exp_q.push_back(x);
                exp_xfers++;
            end
`ifdef BQ_SEQ_READBACK_VERIFY_EN
            if (ok) begin
                x.we = 0; x.dat = 32'h0;
                exp_q.push_back(x);
                exp_xfers++;
                if (i == bad_rd_idx) ok = 0;
            end
`endif
            if (!ok) exp_errs++;
        end
    endtask

    // Slave: decides the termination for the current cycle on the falling edge.
    int wait_left = 0;
    bit s_prev_cyc = 0, s_prev_term = 0;
    always @(negedge wb_clk_i) begin
        bit a, e, r;
        int idx;
        a = 0; e = 0; r = 0;
        m_dat_i = $urandom;
        if (wb_rst_ni && m_cyc_o && m_stb_o) begin
            if (!s_prev_cyc || s_prev_term) wait_left = $urandom_range(0, max_lat);
            idx = int'(m_adr_o[7:2]);
            if (m_we_o && idx == stall_idx && idx != err_idx) begin
                a = 0;
            end else if (wait_left > 0) begin
                wait_left--;
            end else if (m_we_o && idx == err_idx) begin
                e = 1; a = 1'($urandom); r = 1'($urandom);
            end else if (m_we_o && idx == rty_idx && rty_done < rty_n) begin
                r = 1; a = 1'($urandom); rty_done++;
            end else begin
                a = 1;
                if (!m_we_o) m_dat_i = (idx == bad_rd_idx) ? shadow_m[idx] ^ 32'h0000_0100 : shadow_m[idx];
            end
        end
        s_prev_cyc = wb_rst_ni && m_cyc_o && m_stb_o;
        s_prev_term = a | e | r;
        m_ack_i = a; m_err_i = e; m_rty_i = r;
    end

    // Monitor: pops one expected transfer for every new bus issue and checks the address phase holds.
    bit          prev_cyc = 0;
    logic [40:0] held;
    always @(posedge wb_clk_i) begin
        xfer_t x;
        #2;
        if (!wb_rst_ni) begin
            prev_cyc = 0;
        end else begin
            if (m_cyc_o && m_stb_o) begin
                if (!prev_cyc || m_ack_i || m_err_i || m_rty_i) begin
                    n_issue++;
                    held = {m_we_o, m_adr_o, m_dat_o};
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_xfer_adr", {1'b1, m_adr_o}, 9'h0);
                    end else begin
                        x = exp_q.pop_front();
                        checkOutput("xfer_we", m_we_o, x.we);
                        checkOutput("xfer_adr", m_adr_o, x.adr);
                        if (x.we) checkOutput("xfer_dat", m_dat_o, x.dat);
                        checkOutput("xfer_sel", m_sel_o, 4'hF);
                    end
                end else begin
                    checkOutput("xfer_hold", {m_we_o, m_adr_o, m_dat_o}, held);
                end
            end
            if (stall_idx >= 0 && m_cyc_o && m_we_o && int'(m_adr_o[7:2]) == stall_idx) stall_cyc++;
            if (notch_update_o) begin
                notch_n++;
                notch_at = cnt;
                checkOutput("notch_after_all_xfers", exp_q.size(), 0);
            end
            if (done_o) begin
                done_n++;
                done_at = cnt;
            end
            if (busy_o && busy_rise < 0) busy_rise = cnt;
            prev_cyc = m_cyc_o && m_stb_o;
        end
    end

    task automatic writeCfg(input int idx, input logic [31:0] dat);
        @(negedge wb_clk_i);
        cfg_we_i = 1; cfg_idx_i = 6'(idx); cfg_dat_i = dat;
        shadow_m[idx] = dat;
        @(negedge wb_clk_i);
        cfg_we_i = 0;
    endtask

    task automatic startSeq(input int len_req, input bit cfg_same);
        @(negedge wb_clk_i);
        if (cfg_same) begin
            cfg_we_i = 1; cfg_idx_i = 6'd0; cfg_dat_i = $urandom;
            shadow_m[0] = cfg_dat_i;
        end
        rty_done = 0; notch_n = 0; done_n = 0; n_issue = 0; stall_cyc = 0;
        busy_rise = -1; notch_at = -1; done_at = -1;
        buildExpected(len_req);
        commit_i = 1; len_i = 7'(len_req); commit_cnt = cnt;
        @(negedge wb_clk_i);
        commit_i = 0; cfg_we_i = 0;
    endtask

    // Runs one full sequence while hammering the ignored host inputs, then checks the end state.
    task automatic applyStimulus(input int len_req, input bit cfg_same);
        bit fin;
        startSeq(len_req, cfg_same);
        fin = 0;
        for (int c = 0; c < 20000; c++) begin
            if (done_o) begin
                fin = 1;
                break;
            end
            cfg_we_i = 1'($urandom); cfg_idx_i = 6'($urandom); cfg_dat_i = $urandom;
            commit_i = ($urandom_range(0, 3) == 0); len_i = 7'($urandom);
            @(negedge wb_clk_i);
        end
        cfg_we_i = 0; commit_i = 0;
        checkOutput("seq_done_within_bound", fin, 1);
        repeat (2) @(negedge wb_clk_i);
        checkOutput("busy_after_done", busy_o, 0);
        checkOutput("busy_rise_cycle", busy_rise, commit_cnt + 1);
        checkOutput("queue_drained", exp_q.size(), 0);
        checkOutput("xfer_count", n_issue, exp_xfers);
        checkOutput("notch_pulses", notch_n, 1);
        checkOutput("done_pulses", done_n, 1);
        checkOutput("done_after_notch", done_at - notch_at, 1);
        if (len_req == 0) checkOutput("notch_latency_len0", notch_at - commit_cnt, 2);
        checkOutput("err_cnt", err_cnt_o, exp_errs);
        checkOutput("err_o", err_o, exp_errs != 0);
        if (exp_stall) checkOutput("timeout_cycles", stall_cyc, TIMEOUT);
        exp_q.delete();
    endtask

    initial begin
        #(10 * 95000);
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lsel, n, len_req;
        wb_rst_ni = 0; cfg_we_i = 0; commit_i = 0; cfg_idx_i = 0; cfg_dat_i = 0; len_i = 0;
        m_ack_i = 0; m_err_i = 0; m_rty_i = 0; m_dat_i = 0;
        repeat (3) @(negedge wb_clk_i);
        checkOutput("rst_cyc_stb_we", {m_cyc_o, m_stb_o, m_we_o}, 3'b000);
        checkOutput("rst_busy_done_notch", {busy_o, done_o, notch_update_o}, 3'b000);
        checkOutput("rst_err", {err_o, err_cnt_o}, 9'h0);
        checkOutput("rst_adr_dat", {m_adr_o, m_dat_o}, 40'h0);
        checkOutput("rst_sel", m_sel_o, 4'hF);
        wb_rst_ni = 1;

        $display("[TB] full 64-entry load, single-cycle ack");
        for (int i = 0; i < 64; i++) writeCfg(i, 32'hA500_0000 + 32'(i));
        max_lat = 0;
        applyStimulus(64, 0);

        $display("[TB] len=0 update only");
        applyStimulus(0, 0);

        $display("[TB] stalled slave at entry 5");
        stall_idx = 5;
        applyStimulus(8, 0);
        stall_idx = -1;

        $display("[TB] retry limits on entry 0");
        rty_idx = 0; rty_n = 4;
        applyStimulus(4, 0);
        rty_n = 2;
        applyStimulus(4, 0);
        rty_idx = -1;

        $display("[TB] cfg write in commit cycle");
        applyStimulus(3, 1);

        $display("[TB] reset in the middle of a write");
        stall_idx = 0;
        startSeq(2, 0);
        for (int c = 0; c < 20 && !m_cyc_o; c++) @(negedge wb_clk_i);
        checkOutput("rst_test_wr_reached", m_cyc_o, 1);
        repeat (3) @(negedge wb_clk_i);
        #2 wb_rst_ni = 0;
        #1;
        checkOutput("midrst_cyc_stb_busy", {m_cyc_o, m_stb_o, busy_o}, 3'b000);
        exp_q.delete();
        notch_n = 0; done_n = 0;
        repeat (2) @(negedge wb_clk_i);
        wb_rst_ni = 1;
        stall_idx = -1;
        repeat (2) @(negedge wb_clk_i);
        checkOutput("midrst_no_notch_done", {notch_n[7:0], done_n[7:0]}, 16'h0);
        applyStimulus(2, 0);

`ifdef BQ_SEQ_READBACK_VERIFY_EN
        $display("[TB] read-back mismatch on entry 3");
        bad_rd_idx = 3;
        applyStimulus(4, 0);
        bad_rd_idx = -1;
`endif

        $display("[TB] randomized sequences");
        for (int s = 0; s < 12; s++) begin
            for (int w = 0; w < 6; w++) writeCfg($urandom_range(0, 63), $urandom);
            lsel = $urandom_range(0, 5);
            case (lsel)
                0: len_req = 1;
                1: len_req = 64;
                2: len_req = $urandom_range(65, 127);
                default: len_req = $urandom_range(2, 63);
            endcase
            n = (len_req > 64) ? 64 : len_req;
            max_lat = $urandom_range(0, 3);
            err_idx    = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
            stall_idx  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
            rty_idx    = ($urandom_range(0, 1) == 0) ? $urandom_range(0, n - 1) : -1;
            rty_n      = $urandom_range(0, 5);
            bad_rd_idx = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
            applyStimulus(len_req, 1'($urandom));
        end
        err_idx = -1; stall_idx = -1; rty_idx = -1; bad_rd_idx = -1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
